// File: rtl/systolic_matmul_mkn.sv
// systolic_matmul_mkn: output-stationary MxN systolic array computing C = A*B or C += A*B
// with skewed operand feed, signed/unsigned saturating MACs and a valid/ready result handshake.
module systolic_matmul_mkn #(
  parameter int WIDTHX = 4,
  parameter int WIDTH  = 16,
  parameter int M      = 4,
  parameter int K      = 4,
  parameter int N      = 4
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              signed_i,
  input  logic              acc_i,
  input  logic [WIDTHX-1:0] a_input [M-1:0][K-1:0],
  input  logic [WIDTHX-1:0] b_input [K-1:0][N-1:0],
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  output_produc_a_b [M-1:0][N-1:0],
  output logic              ovf_o
);
  localparam int S  = M + N + K - 2;
  localparam int SW = $clog2(S + 1);
  localparam int PW = 2 * WIDTHX;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t            r_state;
  logic              r_sg;
  logic [SW-1:0]     r_step;
  logic [WIDTHX-1:0] r_a_cap [M-1:0][K-1:0];
  logic [WIDTHX-1:0] r_b_cap [K-1:0][N-1:0];
  logic [WIDTHX-1:0] r_a [M-1:0][N-1:0];
  logic [WIDTHX-1:0] r_b [M-1:0][N-1:0];
  logic [WIDTH-1:0]  r_c [M-1:0][N-1:0];
  logic [WIDTHX-1:0] w_a_inj [M-1:0];
  logic [WIDTHX-1:0] w_b_inj [N-1:0];
  logic [WIDTHX-1:0] w_a_in [M-1:0][N-1:0];
  logic [WIDTHX-1:0] w_b_in [M-1:0][N-1:0];
  logic [WIDTH-1:0]  w_nxt [M-1:0][N-1:0];
  logic [M*N-1:0]    w_ov;
  // Edge injection: row i sees a[i][k] at step i+k, column j sees b[k][j] at step j+k.
  always_comb begin
    for (int m = 0; m < M; m++) begin
      w_a_inj[m] = '0;
      for (int k = 0; k < K; k++) if (int'(r_step) == m + k) w_a_inj[m] = r_a_cap[m][k];
    end
    for (int n = 0; n < N; n++) begin
      w_b_inj[n] = '0;
      for (int k = 0; k < K; k++) if (int'(r_step) == n + k) w_b_inj[n] = r_b_cap[k][n];
    end
  end
  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [PW-1:0] w_p;
      logic [WIDTH:0] w_sum;
      logic w_o;
      if (j == 0) begin : g_al
        assign w_a_in[i][j] = w_a_inj[i];
      end else begin : g_ar
        assign w_a_in[i][j] = r_a[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign w_b_in[i][j] = w_b_inj[j];
      end else begin : g_bd
        assign w_b_in[i][j] = r_b[i-1][j];
      end
      assign w_p = {{WIDTHX{r_sg & w_a_in[i][j][WIDTHX-1]}}, w_a_in[i][j]} *
                   {{WIDTHX{r_sg & w_b_in[i][j][WIDTHX-1]}}, w_b_in[i][j]};
      // One guard bit above the accumulator exposes both signed and unsigned overflow.
      assign w_sum = {{(WIDTH+1-PW){r_sg & w_p[PW-1]}}, w_p} + {r_sg & r_c[i][j][WIDTH-1], r_c[i][j]};
      assign w_o = r_sg ? w_sum[WIDTH] ^ w_sum[WIDTH-1] : w_sum[WIDTH];
      assign w_ov[i*N+j] = w_o;
      assign w_nxt[i][j] = !w_o ? w_sum[WIDTH-1:0] :
                           r_sg ? {w_sum[WIDTH], {(WIDTH-1){~w_sum[WIDTH]}}} : '1;
      assign output_produc_a_b[i][j] = r_c[i][j];
    end
  end
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
      r_sg    <= 1'b0;
      r_step  <= '0;
      r_a_cap <= '{default: '0};
      r_b_cap <= '{default: '0};
      r_a     <= '{default: '0};
      r_b     <= '{default: '0};
      r_c     <= '{default: '0};
    end else begin
      case (r_state)
        IDLE: if (valid_i) begin
          r_a_cap <= a_input;
          r_b_cap <= b_input;
          r_sg    <= signed_i;
          r_step  <= '0;
          ready_o <= 1'b0;
          r_state <= COMPUTE;
          r_a     <= '{default: '0};
          r_b     <= '{default: '0};
          if (!acc_i) begin
            r_c   <= '{default: '0};
            ovf_o <= 1'b0;
          end
        end
        COMPUTE: begin
          r_a    <= w_a_in;
          r_b    <= w_b_in;
          r_c    <= w_nxt;
          ovf_o  <= ovf_o | (|w_ov);
          r_step <= r_step + SW'(1);
          if (r_step == SW'(S - 1)) begin
            r_state <= DONE;
            valid_o <= 1'b1;
          end
        end
        DONE: if (ready_i) begin
          valid_o <= 1'b0;
          ready_o <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_matmul_mkn.sv
// tb_systolic_matmul_mkn: scoreboard bench for a 2x3x5 array with 8-bit saturating accumulators.
module tb_systolic_matmul_mkn;
  localparam int WX = 4;
  localparam int W  = 8;
  localparam int M  = 2;
  localparam int K  = 3;
  localparam int N  = 5;
  localparam int S  = M + N + K - 2;
  logic clk = 0, nreset = 0, valid_i = 0, signed_i = 0, acc_i = 0, ready_i = 1;
  logic ready_o, valid_o, ovf_o;
  logic [WX-1:0] a_in [M-1:0][K-1:0];
  logic [WX-1:0] b_in [K-1:0][N-1:0];
  logic [W-1:0]  c_out [M-1:0][N-1:0];
  logic [WX-1:0] pa [M-1:0][K-1:0];
  logic [WX-1:0] pb [K-1:0][N-1:0];
  logic [W-1:0]  mc [M-1:0][N-1:0];
  bit mov;
  typedef struct packed {
    logic [M*N*W-1:0] c;
    logic ovf;
    int t;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit have = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, last_t = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_matmul_mkn #(.WIDTHX(WX), .WIDTH(W), .M(M), .K(K), .N(N)) dut (
    .clock(clk), .nreset(nreset), .valid_i(valid_i), .ready_o(ready_o),
    .signed_i(signed_i), .acc_i(acc_i), .a_input(a_in), .b_input(b_in),
    .valid_o(valid_o), .ready_i(ready_i), .output_produc_a_b(c_out), .ovf_o(ovf_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  function automatic int sx(input logic [31:0] v, input int w, input bit sg);
    return (sg && v[w-1]) ? int'(v) - (1 << w) : int'(v);
  endfunction

  // Reference: per element, MACs applied in ascending k with a clamp after each add.
  function automatic void model(input bit sg, input bit acc);
    int lo = sg ? -(1 << (W - 1)) : 0;
    int hi = sg ? (1 << (W - 1)) - 1 : (1 << W) - 1;
    if (!acc) mov = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int v = acc ? sx(32'(mc[i][j]), W, sg) : 0;
        for (int k = 0; k < K; k++) begin
          v += sx(32'(pa[i][k]), WX, sg) * sx(32'(pb[k][j]), WX, sg);
          if (v > hi) begin v = hi; mov = 1; end
          else if (v < lo) begin v = lo; mov = 1; end
        end
        mc[i][j] = v[W-1:0];
      end
  endfunction

  task automatic fill(input int av, input int bv);
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) pa[i][k] = WX'(av);
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) pb[k][j] = WX'(bv);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) pa[i][k] = WX'($urandom);
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) pb[k][j] = WX'($urandom);
  endtask

  task automatic scramble();
    for (int i = 0; i < M; i++) for (int k = 0; k < K; k++) a_in[i][k] = WX'($urandom);
    for (int k = 0; k < K; k++) for (int j = 0; j < N; j++) b_in[k][j] = WX'($urandom);
    signed_i = 1'($urandom);
    acc_i = 1'($urandom);
  endtask

  task automatic issue(input bit sg, input bit acc, input bit hold);
    int w = 0;
    exp_t e;
    @(negedge clk);
    a_in = pa;
    b_in = pb;
    signed_i = sg;
    acc_i = acc;
    valid_i = 1;
    while (!ready_o && w < 100) begin @(negedge clk); w++; end
    if (!ready_o) begin timeout("accept"); valid_i = 0; return; end
    @(posedge clk);
    #1;
    model(sg, acc);
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) e.c[(i*N+j)*W +: W] = mc[i][j];
    e.ovf = mov;
    e.t = cyc;
    last_t = cyc;
    q.push_back(e);
    if (!hold) valid_i = 0;
    scramble();
  endtask

  task automatic wait_valid();
    int w = 0;
    while (!valid_o && w < 100) begin @(negedge clk); w++; end
    if (!valid_o) timeout("wait_valid");
  endtask

  task automatic drain();
    int w = 0;
    while ((q.size() != 0 || valid_o) && w < 200) begin @(negedge clk); w++; end
    if (q.size() != 0 || valid_o) timeout("drain");
  endtask

  task automatic check_cleared(input string nm);
    chk({nm, "_ready"}, 32'(ready_o), 1);
    chk({nm, "_valid"}, 32'(valid_o), 0);
    chk({nm, "_ovf"}, 32'(ovf_o), 0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) chk($sformatf("%s_C[%0d][%0d]", nm, i, j), 32'(c_out[i][j]), 0);
  endtask

  // Monitor: pops on the rising edge of valid_o, then rechecks the held result each DONE cycle.
  always @(negedge clk) begin
    if (!nreset || !valid_o) have = 0;
    else begin
      if (!have) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_valid: valid_o high with empty scoreboard at cycle %0d", cyc);
        end else begin
          cur = q.pop_front();
          have = 1;
          chk("latency", 32'(cyc - cur.t), S);
        end
      end
      if (have) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            chk($sformatf("C[%0d][%0d]", i, j), 32'(c_out[i][j]), 32'(cur.c[(i*N+j)*W +: W]));
        chk("ovf", 32'(ovf_o), 32'(cur.ovf));
        chk("ready_in_done", 32'(ready_o), 0);
      end
    end
  end

  initial begin
    int t1;
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) mc[i][j] = '0;
    mov = 0;
    fill(0, 0);
    a_in = pa;
    b_in = pb;
    #12;
    check_cleared("reset");
    @(negedge clk) nreset = 1;
    fill(2, 3);    issue(0, 0, 0);
    fill(15, 2);   issue(1, 0, 0);
    fill(15, 2);   issue(0, 0, 0);
    fill(15, 15);  issue(0, 0, 0);
    fill(1, 1);    issue(0, 0, 0);
    fill(8, 8);    issue(1, 0, 0);
    fill(1, 1);    issue(0, 1, 0);
    drain();
    // Backpressure: result must stay frozen while valid_i toggles.
    ready_i = 0;
    fill(1, 1);
    issue(0, 0, 0);
    wait_valid();
    repeat (20) @(negedge clk) begin
      valid_i = ~valid_i;
      scramble();
    end
    @(negedge clk);
    valid_i = 0;
    ready_i = 1;
    fill(1, 1);
    issue(0, 1, 0);
    drain();
    // Back-to-back with valid_i held high: one IDLE cycle between operations.
    fill(3, 5);
    issue(0, 0, 1);
    t1 = last_t;
    fill(7, 9);
    issue(1, 1, 0);
    chk("b2b_gap", 32'(last_t - t1), S + 2);
    for (int n = 0; n < 40; n++) begin
      fill_rand();
      issue(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 3) == 0) begin
        ready_i = 0;
        repeat ($urandom_range(S, S + 6)) @(negedge clk);
        ready_i = 1;
      end
    end
    valid_i = 0;
    drain();
    // Asynchronous reset at step 5 aborts the operation.
    fill(15, 15);
    issue(0, 0, 0);
    repeat (5) @(posedge clk);
    #2 nreset = 0;
    #1 check_cleared("midreset");
    q.delete();
    for (int i = 0; i < M; i++) for (int j = 0; j < N; j++) mc[i][j] = '0;
    mov = 0;
    @(negedge clk) nreset = 1;
    fill(2, 3);
    issue(0, 1, 0);
    fill_rand();
    issue(1, 1, 0);
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/systolic_matmul_mkn.md
Name: systolic_matmul_mkn

Overview:
Parametrised successor to the square systolic multiplier. It computes C = A·B for rectangular A (M×K) and B (K×N) on an output-stationary M×N processing-element (PE) array, with skewed operand feed.
- New capabilities: signed/unsigned mode, accumulate mode (C += A·B), per-MAC saturation with a sticky overflow flag, and a full valid/ready handshake on the result side.
- Sits between the matrix operand loader and the result consumer/writeback.

Parameters:
WIDTHX, 4, operand element width (bits)
WIDTH, 16, result/accumulator element width (bits), WIDTH ≥ 2*WIDTHX
M, 4, rows of A and C
K, 4, columns of A = rows of B (inner dimension)
N, 4, columns of B and C

Ports:
clock  in  1  single clock, rising edge
nreset  in  1  asynchronous active-low reset
valid_i  in  1  operand request; accepted when valid_i && ready_o at a rising edge
ready_o  out  1  high only in IDLE
signed_i  in  1  sampled at accept; 1 = two's-complement operands and result
acc_i  in  1  sampled at accept; 1 = accumulate onto current C, 0 = clear C first
a_input  in  M×K×WIDTHX  unpacked array [M-1:0][K-1:0]
b_input  in  K×N×WIDTHX  unpacked array [K-1:0][N-1:0]
valid_o  out  1  result valid, high in DONE
ready_i  in  1  consumer accepts result when valid_o && ready_i
output_produc_a_b  out  M×N×WIDTH  unpacked array [M-1:0][N-1:0], direct view of PE accumulators
ovf_o  out  1  sticky saturation flag for the current result

Behaviour:
- Reset (nreset low, asynchronous) forces:
  - state = IDLE; valid_o = 0; ready_o = 1; ovf_o = 0;
  - all accumulators = 0; step counter = 0.
  - Reset asserted mid-COMPUTE or mid-DONE aborts the operation; no partial result is flagged valid.
- State IDLE:
  - ready_o = 1.
  - On an accept edge:
    - capture a_input, b_input, signed_i and acc_i into internal registers;
    - if acc_i = 0, clear accumulators and ovf_o; otherwise keep both;
    - step = 0; go to COMPUTE.
- State COMPUTE:
  - ready_o = 0; valid_i is ignored.
  - Each edge performs one systolic step c. PE(i,j) performs its MAC for every k with i+j+k == c.
  - The skew is realised by row/column shift registers. A values move right and B values move down, one PE per cycle.
  - Total steps S = M+N+K-2. At the edge executing step S-1, go to DONE and set valid_o = 1.
  - Latency: valid_o rises exactly S edges after the accept edge. Defaults give S = 10.
- State DONE:
  - valid_o = 1. output_produc_a_b and ovf_o are held stable.
  - On an edge with ready_i = 1: valid_o = 0, go to IDLE.
  - Accumulators keep their value after the handshake, which provides the base for a following acc_i = 1 operation.
- Arithmetic:
  - Products are formed at 2*WIDTHX, sign- or zero-extended per the captured signed_i.
  - Every MAC is a saturating add at WIDTH bits:
    - unsigned: clamp to 2^WIDTH-1;
    - signed: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Any clamp sets ovf_o, which stays set until reset or the next accept with acc_i = 0.
- Boundary conditions:
  - M, N or K = 1 must work, e.g. S = 1 for 1×1×1.
  - valid_i held high continuously gives back-to-back operations: one IDLE cycle between DONE-accept and the next accept.
  - Operand changes after the accept edge have no effect.
  - ready_i asserted outside DONE is ignored.
  - signed_i and acc_i are don't-care except at the accept edge.

Test Plan:
- Identity, defaults: A = I4, B[k][j] = 4k+j+1, acc_i = 0, unsigned → C == B; valid_o high exactly 10 cycles after the accept edge; ovf_o = 0.
- Rectangular, M=2 K=3 N=5: A all 2, B all 3 → every C = 18; latency 8 cycles.
- Signed, defaults: A all 4'hF (-1), B all 4'h2, signed_i = 1 → every C = 16'hFFF8 (-8); the same data with signed_i = 0 → every C = 120.
- Saturation, WIDTH=8: A and B all 15, unsigned → every C = 255, ovf_o = 1. Next operation with acc_i = 0 and A = B = all 1 → C = 4, ovf_o = 0.
- Accumulate and backpressure, defaults:
  - A = B = all 1, acc_i = 0 → C = 4.
  - Hold ready_i = 0 for 20 cycles while pulsing valid_i → C, valid_o and ovf_o stay stable, ready_o = 0.
  - Release ready_i, then issue the same operands with acc_i = 1 → C = 8.
- Reset mid-compute: assert nreset low at step 5 → immediately valid_o = 0, ready_o = 1, all C = 0, ovf_o = 0. A fresh operation afterwards completes correctly.
